// File: rtl/ex_mdu_pkg.sv
// Shared defines for the execute-stage multiply/divide unit: opcodes, divider
// state encodings, stall constants and the HI/LO payload type.
package ex_mdu_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALUOP_W    = 8;
  localparam int unsigned CNT_W      = 6;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [ALUOP_W-1:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [ALUOP_W-1:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [ALUOP_W-1:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [ALUOP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [ALUOP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam logic STALL    = 1'b1;
  localparam logic NO_STALL = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

  // Magnitude of a value that is two's complement only when sgn is set.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? DATA_W'(-v) : v;
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Restoring radix-2 divider, one quotient bit per cycle; result is {rem, quo}.
// Compiled only when MDU_DIV_EN is defined.
`ifdef MDU_DIV_EN
module mdu_div
  import ex_mdu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic              annul_i,
  input  logic [DATA_W-1:0] op1_i,
  input  logic [DATA_W-1:0] op2_i,
  output logic              ready_o,
  output hilo_t             result_o
);

  div_state_e        r_state;
  div_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_dvs;
  logic              r_neg_q;
  logic              r_neg_r;
  hilo_t             r_result;

  logic [DATA_W:0]   w_trial;
  logic [DATA_W-1:0] w_rem_nxt;
  logic [DATA_W-1:0] w_quo_nxt;
  logic [DATA_W-1:0] w_q_fix;
  logic [DATA_W-1:0] w_r_fix;
  logic              w_last;

  assign w_last = (r_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= DivFree;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (annul_i) begin
      w_state_nxt = DivFree;
    end else begin
      case (r_state)
        DivFree:   if (start_i) w_state_nxt = (op2_i == '0) ? DivByZero : DivOn;
        DivByZero: w_state_nxt = DivEnd;
        DivOn:     if (w_last) w_state_nxt = DivEnd;
        DivEnd:    w_state_nxt = DivFree;
        default:   w_state_nxt = DivFree;
      endcase
    end
  end

  // Shift in the next dividend bit and subtract the divisor if it fits.
  always_comb begin
    w_trial = {r_rem, r_quo[DATA_W-1]} - {1'b0, r_dvs};
    if (!w_trial[DATA_W]) begin
      w_rem_nxt = w_trial[DATA_W-1:0];
      w_quo_nxt = {r_quo[DATA_W-2:0], 1'b1};
    end else begin
      w_rem_nxt = {r_rem[DATA_W-2:0], r_quo[DATA_W-1]};
      w_quo_nxt = {r_quo[DATA_W-2:0], 1'b0};
    end
    w_q_fix = r_neg_q ? DATA_W'(-w_quo_nxt) : w_quo_nxt;
    w_r_fix = r_neg_r ? DATA_W'(-w_rem_nxt) : w_rem_nxt;
  end

  // On a zero divisor r_quo keeps the raw dividend, which becomes the remainder.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        DivFree: begin
          if (start_i) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= (op2_i == '0) ? op1_i : mag(op1_i, signed_i);
            r_dvs   <= mag(op2_i, signed_i);
            r_neg_q <= signed_i & (op1_i[DATA_W-1] ^ op2_i[DATA_W-1]);
            r_neg_r <= signed_i & op1_i[DATA_W-1];
          end
        end
        DivByZero: r_result <= '{hi: r_quo, lo: '1};
        DivOn: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_result <= '{hi: w_r_fix, lo: w_q_fix};
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = (r_state == DivEnd);
  assign result_o = r_result;

endmodule
`endif

// File: rtl/ex_mdu.sv
// Execute-stage multiply/divide unit: HI/LO registers, MFHI/MFLO read mux,
// single-cycle multiplier and optional divider (enabled by MDU_DIV_EN).
module ex_mdu
  import ex_mdu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [DATA_W-1:0]     reg1_i,
  input  logic [DATA_W-1:0]     reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  annul_i,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic                  stallreq_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o
);

  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic [2*DATA_W-1:0] w_prod_s;
  logic [2*DATA_W-1:0] w_prod_u;
  logic                w_div_wr;
  hilo_t               w_div_result;

  assign w_prod_s = 64'($signed(reg1_i)) * 64'($signed(reg2_i));
  assign w_prod_u = 64'(reg1_i) * 64'(reg2_i);

`ifdef MDU_DIV_EN
  logic  w_is_div;
  logic  w_div_ready;

  assign w_is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

  mdu_div u_div (
    .clk      (clk),
    .rst      (rst),
    .start_i  (w_is_div),
    .signed_i (aluop_i == EXE_DIV_OP),
    .annul_i  (annul_i),
    .op1_i    (reg1_i),
    .op2_i    (reg2_i),
    .ready_o  (w_div_ready),
    .result_o (w_div_result)
  );

  assign stallreq_o = (!rst && w_is_div && !w_div_ready && !annul_i) ? STALL : NO_STALL;
  assign w_div_wr   = w_is_div && w_div_ready && !annul_i;
`else
  logic w_unused_annul;

  assign w_unused_annul = annul_i;
  assign stallreq_o     = NO_STALL;
  assign w_div_wr       = 1'b0;
  assign w_div_result   = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      case (aluop_i)
        EXE_MTHI_OP:  r_hi <= reg1_i;
        EXE_MTLO_OP:  r_lo <= reg1_i;
        EXE_MULT_OP:  {r_hi, r_lo} <= w_prod_s;
        EXE_MULTU_OP: {r_hi, r_lo} <= w_prod_u;
        default: begin
          if (w_div_wr) {r_hi, r_lo} <= w_div_result;
        end
      endcase
    end
  end

  // Move-from reads bypass nothing: HI/LO are already updated one edge after the write.
  always_comb begin
    wdata_o = '0;
    if (!rst) begin
      case (aluop_i)
        EXE_MFHI_OP: wdata_o = r_hi;
        EXE_MFLO_OP: wdata_o = r_lo;
        default:     wdata_o = '0;
      endcase
    end
  end

  assign wd_o   = wd_i;
  assign wreg_o = wreg_i;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 SHALL: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL: aluop_i  in  8  decoded ALU opcode from the decode stage, EXE_*_OP encoding.
REQ-004 SHALL: reg1_i  in  32  operand 1 (rs, forwarded).
REQ-005 SHALL: reg2_i  in  32  operand 2 (rt, forwarded).
REQ-006 SHALL: wd_i  in  5  destination register address.
REQ-007 SHALL: wreg_i  in  1  destination write enable.
REQ-008 SHALL: annul_i  in  1  cancel an in-flight divide.
REQ-009 SHALL: wdata_o  out  32  GPR write-back data.
REQ-010 SHALL: wd_o  out  5  equal to wd_i.
REQ-011 SHALL: wreg_o  out  1  equal to wreg_i.
REQ-012 SHALL: stallreq_o  out  1  pipeline stall request.
REQ-013 SHALL: hi_o  out  32  current HI register.
REQ-014 SHALL: lo_o  out  32  current LO register.

Function
REQ-015 SHALL: MFHI/MFLO drive wdata_o = HI/LO combinationally in the same cycle; all other ops drive wdata_o = 0.
REQ-016 SHALL: MTHI/MTLO write reg1_i into HI/LO at the next clock edge; the other register is unchanged.
REQ-017 SHALL: MULT (signed) / MULTU (unsigned) write the 64-bit product {HI,LO} at the next clock edge with 1-cycle latency and no stall.
REQ-018 SHALL: DIV/DIVU use a restoring radix-2 divider FSM with states IDLE, ZERO, ON, END.
REQ-019 SHALL: IDLE + DIV op go to ZERO if reg2_i == 0, else to ON with iteration counter 0.
REQ-020 SHALL: ON runs exactly 32 iterations, one per cycle, then goes to END.
REQ-021 SHALL: ZERO lasts one cycle, then goes to END with quotient 0xFFFFFFFF and remainder = dividend.
REQ-022 SHALL: in END, HI = remainder and LO = quotient are written at the clock edge leaving END; the state returns to IDLE.
REQ-023 SHALL: stallreq_o = 1 while aluop_i is DIV/DIVU and state != END: 33 cycles for a normal divide, 2 cycles for divide-by-zero.
REQ-024 SHALL: signed DIV divides magnitudes; quotient is negated when operand signs differ; remainder takes the dividend sign.
REQ-025 SHALL: 0x80000000 / 0xFFFFFFFF (DIV) yields LO = 0x80000000, HI = 0.
REQ-026 SHALL: operands are latched on leaving IDLE, so later changes to reg1_i/reg2_i do not affect the result.
REQ-027 SHALL: annul_i = 1 in any state forces IDLE at the next edge, with no HI/LO write and stallreq_o = 0 in that cycle.
REQ-028 SHALL: an MFHI in the cycle after MTHI/MULT/DIV-END returns the updated value.

Reset
REQ-029 SHALL: rst sets HI = LO = 0, the FSM to IDLE and the counter to 0; while rst is high, wdata_o = 0 and stallreq_o = 0.
REQ-030 SHALL: rst during ON or ZERO abandons the divide without writing HI/LO.

Configuration
REQ-031 SHALL: macro MDU_DIV_EN defined: the divider FSM is compiled in (REQ-018..REQ-027 apply).
REQ-032 SHALL: MDU_DIV_EN undefined: DIV/DIVU act as NOP, stallreq_o = 0 constantly, HI/LO are unchanged, and annul_i is ignored.

Structure
REQ-033 SHALL: the EXE_*_OP opcodes, the divider state encodings (DivFree, DivByZero, DivOn, DivEnd) and the stall constants live in the shared defines package.
REQ-034 SHALL: the divider is the sub-module mdu_div (start, signed, annul, operands in; ready, 64-bit result out); ex_mdu holds HI/LO and the mux.

Verification
REQ-035 SHALL: MTHI reg1 = 0x12345678, then MFHI -> wdata_o = 0x12345678 the next cycle.
REQ-036 SHALL: MULT 0xFFFFFFFE x 0x00000003 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFA after 1 cycle; MULTU with the same operands -> HI = 0x2, LO = 0xFFFFFFFA.
REQ-037 SHALL: DIV 0xFFFFFFF9 (-7) / 2 -> stallreq_o high for 33 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
REQ-038 SHALL: DIVU 100 / 0 -> stallreq_o high for 2 cycles, then LO = 0xFFFFFFFF, HI = 100.
REQ-039 SHALL: DIVU 100 / 7 with annul_i pulsed at iteration 10 -> FSM IDLE, HI/LO unchanged; a following DIVU 100 / 7 gives LO = 14, HI = 2.
REQ-040 SHALL: rst asserted mid-divide -> HI = LO = 0, stallreq_o = 0 the next cycle.
